// File: rtl/ldpc_pkg.sv
// ldpc_pkg: scheduler state encoding and index-width helpers shared by the
// LDPC scheduler and datapath.
package ldpc_pkg;
   typedef enum logic [2:0] {IDLE, INIT, ISSUE, DRAIN, CHECK, DONE} ldpc_sched_state_t;
   localparam int unsigned LDPC_K = 1023;
   localparam int unsigned LDPC_M = 175;
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int unsigned LDPC_KW = idx_w(LDPC_K);
   localparam int unsigned LDPC_MW = idx_w(LDPC_M);
   localparam int unsigned LDPC_RW = idx_w(LDPC_M + 1);
endpackage

// File: rtl/ldpc_syndrome_acc.sv
// ldpc_syndrome_acc: counts returned parity results for one iteration and
// ORs their fail bits into the syndrome flag.
module ldpc_syndrome_acc
   import ldpc_pkg::*;
#(
   parameter int unsigned M = LDPC_M
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   input  logic fail_i,
   output logic syn_o,
   output logic full_o
);
   localparam int unsigned RW = idx_w(M + 1);
   localparam logic [RW-1:0] M_CNT = RW'(M);
   logic [RW-1:0] cnt_q;
   logic          syn_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         syn_q <= 1'b0;
      end else if (clr_i) begin
         cnt_q <= '0;
         syn_q <= 1'b0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 1'b1;
         syn_q <= syn_q | fail_i;
      end
   end
   assign syn_o  = syn_q;
   assign full_o = cnt_q == M_CNT;
endmodule

// File: rtl/ldpc_iter_sched.sv
// ldpc_iter_sched: sequences LLR init, then per-iteration check-row passes until
// the syndrome clears or max_loops is hit. Macro SYNDROME_EARLY_EXIT_EN enables early exit.
module ldpc_iter_sched
   import ldpc_pkg::*;
#(
   parameter int unsigned K = LDPC_K,
   parameter int unsigned M = LDPC_M,
   parameter int unsigned MAX_LOOPS_WIDTH = 64,
   localparam int unsigned KW = idx_w(K),
   localparam int unsigned MW = idx_w(M),
   localparam int unsigned RW = idx_w(M + 1)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       start_i,
   input  logic [MAX_LOOPS_WIDTH-1:0] max_loops_i,
   output logic                       init_valid_o,
   output logic [KW-1:0]              init_addr_o,
   output logic                       row_valid_o,
   input  logic                       row_ready_i,
   output logic [MW-1:0]              row_idx_o,
   input  logic                       par_valid_i,
   input  logic                       par_fail_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       success_o,
   output logic [MAX_LOOPS_WIDTH-1:0] iter_count_o
);
   localparam logic [KW-1:0] K_LAST = KW'(K - 1);
   localparam logic [RW-1:0] M_LAST = RW'(M - 1);
   ldpc_sched_state_t state_q, state_d;
   logic [KW-1:0] addr_q, addr_d;
   logic [RW-1:0] row_q, row_d;
   logic [MAX_LOOPS_WIDTH-1:0] iter_q, iter_d, max_q, max_d, iter_nx;
   logic succ_q, succ_d, clr, syn, full, stop, acc_en;
   assign acc_en  = par_valid_i && (state_q == ISSUE || state_q == DRAIN);
   assign iter_nx = iter_q + 1'b1;
`ifdef SYNDROME_EARLY_EXIT_EN
   assign stop = !syn || iter_nx == max_q;
`else
   assign stop = iter_nx == max_q;
`endif
   ldpc_syndrome_acc #(.M(M)) u_acc (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr),
      .en_i   (acc_en),
      .fail_i (par_fail_i),
      .syn_o  (syn),
      .full_o (full)
   );
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      row_d   = row_q;
      iter_d  = iter_q;
      max_d   = max_q;
      succ_d  = succ_q;
      clr     = 1'b0;
      case (state_q)
         IDLE: if (start_i) begin
            state_d = INIT;
            addr_d  = '0;
            row_d   = '0;
            iter_d  = '0;
            max_d   = max_loops_i;
            succ_d  = 1'b0;
            clr     = 1'b1;
         end
         INIT: begin
            addr_d = addr_q + 1'b1;
            if (addr_q == K_LAST) state_d = (max_q == '0) ? DONE : ISSUE;
         end
         ISSUE: if (row_ready_i) begin
            row_d = row_q + 1'b1;
            if (row_q == M_LAST) state_d = DRAIN;
         end
         DRAIN: if (full) state_d = CHECK;
         CHECK: begin
            iter_d  = iter_nx;
            succ_d  = !syn;
            state_d = stop ? DONE : ISSUE;
            row_d   = stop ? row_q : '0;
            clr     = !stop;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         row_q   <= '0;
         iter_q  <= '0;
         max_q   <= '0;
         succ_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         row_q   <= row_d;
         iter_q  <= iter_d;
         max_q   <= max_d;
         succ_q  <= succ_d;
      end
   end
   assign init_valid_o = state_q == INIT;
   assign init_addr_o  = addr_q;
   assign row_valid_o  = state_q == ISSUE;
   assign row_idx_o    = row_q[MW-1:0];
   assign busy_o       = state_q != IDLE;
   assign done_o       = state_q == DONE;
   assign success_o    = succ_q;
   assign iter_count_o = iter_q;
endmodule

// File: tb/tb_ldpc_iter_sched.sv
// tb_ldpc_iter_sched: directed checks of the LDPC iteration scheduler at K=4, M=3,
// with a datapath stand-in that returns results same-cycle or 3 cycles late.
module tb_ldpc_iter_sched;
   localparam int K = 4;
   localparam int M = 3;
   localparam int W = 64;
`ifdef SYNDROME_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n, start, row_ready, par_fail, par_valid;
   logic [W-1:0] max_loops, iter_count;
   logic init_valid, row_valid, busy, done, success;
   logic [1:0] init_addr, row_idx;
   logic dly;
   logic [2:0] pipe;
   int stall_row = 0, stall_n = 0;
   int passed = 0, total = 0;

   ldpc_iter_sched #(.K(K), .M(M), .MAX_LOOPS_WIDTH(W)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .max_loops_i  (max_loops),
      .init_valid_o (init_valid),
      .init_addr_o  (init_addr),
      .row_valid_o  (row_valid),
      .row_ready_i  (row_ready),
      .row_idx_o    (row_idx),
      .par_valid_i  (par_valid),
      .par_fail_i   (par_fail),
      .busy_o       (busy),
      .done_o       (done),
      .success_o    (success),
      .iter_count_o (iter_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) pipe <= '0;
      else pipe <= {pipe[1:0], row_valid & row_ready};
   assign par_valid = dly ? pipe[2] : (row_valid & row_ready);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Cycle 1 is the cycle after the edge that accepts start.
   task automatic run_decode(input logic [W-1:0] ml, output int done_cyc, output int hs_n,
                             output bit seq_ok, output bit init_ok, output bit rv_seen,
                             output bit stable_ok);
      bit prev_stall = 1'b0;
      logic [1:0] prev_idx = '0;
      start = 1'b1;
      max_loops = ml;
      step();
      start = 1'b0;
      max_loops = '0;
      done_cyc = -1; hs_n = 0; seq_ok = 1'b1; init_ok = 1'b1; rv_seen = 1'b0; stable_ok = 1'b1;
      for (int c = 1; c <= 2000 && done_cyc < 0; c++) begin
         if (init_valid !== (c <= K)) init_ok = 1'b0;
         if (c <= K && init_addr !== 2'(c - 1)) init_ok = 1'b0;
         if (row_valid === 1'b1) rv_seen = 1'b1;
         if (prev_stall && !(row_valid === 1'b1 && row_idx === prev_idx)) stable_ok = 1'b0;
         row_ready = !(row_valid && row_idx == 2'(stall_row) && stall_n > 0);
         if (!row_ready) stall_n--;
         if (row_valid && row_ready) begin
            if (row_idx !== 2'(hs_n % M)) seq_ok = 1'b0;
            hs_n++;
         end
         prev_stall = row_valid && !row_ready;
         prev_idx = row_idx;
         if (done === 1'b1) done_cyc = c;
         step();
      end
      row_ready = 1'b1;
   endtask

   task automatic test_reset();
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
      total++; if ({init_valid, row_valid} !== 2'b00) $display("FAIL reset_valids: got %b want 00", {init_valid, row_valid}); else passed++;
      total++; if ({success, iter_count} !== '0) $display("FAIL reset_result: got succ=%b iter=%0d want 0/0", success, iter_count); else passed++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_all_pass();
      int dc, hs; bit sq, io, rv, st;
      par_fail = 1'b0;
      run_decode(5, dc, hs, sq, io, rv, st);
      total++; if (io !== 1'b1) $display("FAIL pass_init_seq: got %b want 1", io); else passed++;
      total++; if (dc !== (EARLY ? 10 : 30)) $display("FAIL pass_done_cycle: got %0d want %0d", dc, EARLY ? 10 : 30); else passed++;
      total++; if (success !== 1'b1) $display("FAIL pass_success: got %b want 1", success); else passed++;
      total++; if (iter_count !== W'(EARLY ? 1 : 5)) $display("FAIL pass_iter: got %0d want %0d", iter_count, EARLY ? 1 : 5); else passed++;
      total++; if (hs !== (EARLY ? 3 : 15) || !sq) $display("FAIL pass_rows: got %0d rows order_ok=%b want %0d", hs, sq, EARLY ? 3 : 15); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL pass_idle: got busy=%b want 0", busy); else passed++;
   endtask

   task automatic test_all_fail();
      int dc, hs; bit sq, io, rv, st;
      par_fail = 1'b1;
      run_decode(5, dc, hs, sq, io, rv, st);
      total++; if (dc !== 30) $display("FAIL fail_done_cycle: got %0d want 30", dc); else passed++;
      total++; if (success !== 1'b0) $display("FAIL fail_success: got %b want 0", success); else passed++;
      total++; if (iter_count !== W'(5)) $display("FAIL fail_iter: got %0d want 5", iter_count); else passed++;
      total++; if (hs !== 15 || !sq) $display("FAIL fail_rows: got %0d rows order_ok=%b want 15", hs, sq); else passed++;
      par_fail = 1'b0;
   endtask

   task automatic test_max_loops3();
      int dc, hs; bit sq, io, rv, st;
      run_decode(3, dc, hs, sq, io, rv, st);
      total++; if (dc !== (EARLY ? 10 : 20)) $display("FAIL ml3_done_cycle: got %0d want %0d", dc, EARLY ? 10 : 20); else passed++;
      total++; if (success !== 1'b1) $display("FAIL ml3_success: got %b want 1", success); else passed++;
      total++; if (iter_count !== W'(EARLY ? 1 : 3)) $display("FAIL ml3_iter: got %0d want %0d", iter_count, EARLY ? 1 : 3); else passed++;
   endtask

   task automatic test_stall();
      int dc, hs; bit sq, io, rv, st;
      dly = 1'b1; stall_row = 1; stall_n = 2;
      run_decode(1, dc, hs, sq, io, rv, st);
      total++; if (st !== 1'b1) $display("FAIL stall_stable: got %b want 1", st); else passed++;
      total++; if (hs !== 3 || !sq) $display("FAIL stall_rows: got %0d rows order_ok=%b want 3", hs, sq); else passed++;
      total++; if (dc !== 15) $display("FAIL stall_done_cycle: got %0d want 15", dc); else passed++;
      total++; if ({success, iter_count} !== {1'b1, W'(1)}) $display("FAIL stall_result: got succ=%b iter=%0d want 1/1", success, iter_count); else passed++;
      dly = 1'b0; stall_n = 0;
   endtask

   task automatic test_back_to_back();
      int dc, hs; bit sq, io, rv, st;
      run_decode(0, dc, hs, sq, io, rv, st);
      total++; if (dc !== 5) $display("FAIL zero_done_cycle: got %0d want 5", dc); else passed++;
      total++; if (rv !== 1'b0) $display("FAIL zero_row_valid: got %b want 0", rv); else passed++;
      total++; if (io !== 1'b1) $display("FAIL zero_init_seq: got %b want 1", io); else passed++;
      total++; if ({success, iter_count} !== '0) $display("FAIL zero_result: got succ=%b iter=%0d want 0/0", success, iter_count); else passed++;
      par_fail = 1'b1;
      run_decode(1, dc, hs, sq, io, rv, st);
      total++; if (dc !== 10) $display("FAIL b2b_done_cycle: got %0d want 10", dc); else passed++;
      total++; if ({success, iter_count} !== {1'b0, W'(1)}) $display("FAIL b2b_result: got succ=%b iter=%0d want 0/1", success, iter_count); else passed++;
      par_fail = 1'b0;
   endtask

   task automatic test_reset_mid();
      int dc, hs; bit sq, io, rv, st;
      bit saw_done = 1'b0;
      par_fail = 1'b1;
      start = 1'b1; max_loops = 5;
      step();
      start = 1'b0; max_loops = '0;
      repeat (2) step();
      start = 1'b1;
      step();
      start = 1'b0;
      total++; if ({init_valid, init_addr} !== 3'b111) $display("FAIL busy_start_init: got %b want 111", {init_valid, init_addr}); else passed++;
      repeat (3) step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      total++; if ({row_valid, row_idx, iter_count} !== {3'b101, W'(1)}) $display("FAIL mid_issue2: got rv=%b idx=%0d iter=%0d want 1/1/1", row_valid, row_idx, iter_count); else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++; if ({busy, row_valid, init_valid} !== 3'b000) $display("FAIL mid_reset_outs: got %b want 000", {busy, row_valid, init_valid}); else passed++;
      total++; if (iter_count !== '0) $display("FAIL mid_reset_iter: got %0d want 0", iter_count); else passed++;
      repeat (3) begin
         step();
         saw_done |= done;
      end
      rst_n = 1'b1;
      step();
      saw_done |= done;
      total++; if (saw_done !== 1'b0) $display("FAIL mid_reset_done: got %b want 0", saw_done); else passed++;
      par_fail = 1'b0;
      run_decode(2, dc, hs, sq, io, rv, st);
      total++; if (dc !== (EARLY ? 10 : 15)) $display("FAIL post_reset_done: got %0d want %0d", dc, EARLY ? 10 : 15); else passed++;
      total++; if ({success, iter_count} !== {1'b1, W'(EARLY ? 1 : 2)}) $display("FAIL post_reset_result: got succ=%b iter=%0d want 1/%0d", success, iter_count, EARLY ? 1 : 2); else passed++;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; max_loops = '0; row_ready = 1'b1; par_fail = 1'b0; dly = 1'b0;
      step();
      test_reset();
      test_all_pass();
      test_all_fail();
      test_max_loops3();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
